// File: rtl/arc4_key_sched.sv
// ARC4 key-search scheduler: walks candidate keys through init -> KSA -> PRGA
// and arbitrates the single S-memory port between the three cores.
module arc4_key_sched #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [23:0] KEY_END   = 24'hFFFFFF,
   parameter logic [23:0] KEY_STEP  = 24'h000001
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   output logic        o_rdy,
   output logic        o_key_valid,
   output logic [23:0] o_key,
   output logic [23:0] o_cur_key,
   output logic        o_init_en,
   output logic        o_ksa_en,
   output logic        o_prga_en,
   input  logic        i_init_rdy,
   input  logic        i_ksa_rdy,
   input  logic        i_prga_rdy,
   input  logic        i_prga_key_fail,
   input  logic [7:0]  i_init_s_addr,
   input  logic [7:0]  i_ksa_s_addr,
   input  logic [7:0]  i_prga_s_addr,
   input  logic [7:0]  i_init_s_wrdata,
   input  logic [7:0]  i_ksa_s_wrdata,
   input  logic [7:0]  i_prga_s_wrdata,
   input  logic        i_init_s_wren,
   input  logic        i_ksa_s_wren,
   input  logic        i_prga_s_wren,
   output logic [7:0]  o_s_addr,
   output logic [7:0]  o_s_wrdata,
   output logic        o_s_wren
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_INIT_GO   = 4'd1,
      S_INIT_ACK  = 4'd2,
      S_INIT_WAIT = 4'd3,
      S_KSA_GO    = 4'd4,
      S_KSA_ACK   = 4'd5,
      S_KSA_WAIT  = 4'd6,
      S_PRGA_GO   = 4'd7,
      S_PRGA_ACK  = 4'd8,
      S_PRGA_WAIT = 4'd9,
      S_CHECK     = 4'd10,
      S_FOUND     = 4'd11,
      S_EXHAUST   = 4'd12
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [23:0] r_cur_key;
   logic [23:0] r_key;
   logic        r_key_valid;
   logic        r_fail;
   logic [24:0] w_sum;
   logic        w_last;

   // The sum is kept 25 bits wide so a step past 24'hFFFFFF ends the range instead of wrapping.
   assign w_sum  = {1'b0, r_cur_key} + {1'b0, KEY_STEP};
   assign w_last = (r_cur_key == KEY_END) || (w_sum > {1'b0, KEY_END});

   assign o_rdy       = (r_state == S_IDLE);
   assign o_key_valid = r_key_valid;
   assign o_key       = r_key_valid ? r_key : r_cur_key;
   assign o_cur_key   = r_cur_key;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cur_key   <= KEY_START;
         r_key       <= KEY_START;
         r_key_valid <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_en) begin
                  r_cur_key   <= KEY_START;
                  r_key_valid <= 1'b0;
                  r_fail      <= 1'b0;
               end
            end
            S_PRGA_ACK, S_PRGA_WAIT: begin
               if (i_prga_key_fail) begin
                  r_fail <= 1'b1;
               end
            end
            S_CHECK: begin
               if (r_fail && !w_last) begin
                  r_cur_key <= w_sum[23:0];
                  r_fail    <= 1'b0;
               end
            end
            S_FOUND: begin
               r_key       <= r_cur_key;
               r_key_valid <= 1'b1;
            end
            S_EXHAUST: begin
               r_key_valid <= 1'b0;
            end
            default: begin
               r_fail <= r_fail;
            end
         endcase
      end
   end

   // ACK states wait for the core to drop rdy so a late-falling rdy is not mistaken for completion.
   always_comb begin
      w_next    = r_state;
      o_init_en = 1'b0;
      o_ksa_en  = 1'b0;
      o_prga_en = 1'b0;
      case (r_state)
         S_IDLE:      if (i_en) w_next = S_INIT_GO; else w_next = S_IDLE;
         S_INIT_GO: begin
            if (i_init_rdy) begin
               o_init_en = 1'b1;
               w_next    = S_INIT_ACK;
            end else begin
               w_next = S_INIT_GO;
            end
         end
         S_INIT_ACK:  if (!i_init_rdy) w_next = S_INIT_WAIT; else w_next = S_INIT_ACK;
         S_INIT_WAIT: if (i_init_rdy) w_next = S_KSA_GO; else w_next = S_INIT_WAIT;
         S_KSA_GO: begin
            if (i_ksa_rdy) begin
               o_ksa_en = 1'b1;
               w_next   = S_KSA_ACK;
            end else begin
               w_next = S_KSA_GO;
            end
         end
         S_KSA_ACK:   if (!i_ksa_rdy) w_next = S_KSA_WAIT; else w_next = S_KSA_ACK;
         S_KSA_WAIT:  if (i_ksa_rdy) w_next = S_PRGA_GO; else w_next = S_KSA_WAIT;
         S_PRGA_GO: begin
            if (i_prga_rdy) begin
               o_prga_en = 1'b1;
               w_next    = S_PRGA_ACK;
            end else begin
               w_next = S_PRGA_GO;
            end
         end
         S_PRGA_ACK:  if (!i_prga_rdy) w_next = S_PRGA_WAIT; else w_next = S_PRGA_ACK;
         S_PRGA_WAIT: if (i_prga_rdy) w_next = S_CHECK; else w_next = S_PRGA_WAIT;
         S_CHECK: begin
            if (!r_fail) begin
               w_next = S_FOUND;
            end else if (w_last) begin
               w_next = S_EXHAUST;
            end else begin
               w_next = S_INIT_GO;
            end
         end
         S_FOUND:     w_next = S_IDLE;
         S_EXHAUST:   w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // S-memory grant follows the phase; ungranted requesters never reach the port.
   always_comb begin
      o_s_addr   = 8'd0;
      o_s_wrdata = 8'd0;
      o_s_wren   = 1'b0;
      case (r_state)
         S_INIT_GO, S_INIT_ACK, S_INIT_WAIT: begin
            o_s_addr   = i_init_s_addr;
            o_s_wrdata = i_init_s_wrdata;
            o_s_wren   = i_init_s_wren;
         end
         S_KSA_GO, S_KSA_ACK, S_KSA_WAIT: begin
            o_s_addr   = i_ksa_s_addr;
            o_s_wrdata = i_ksa_s_wrdata;
            o_s_wren   = i_ksa_s_wren;
         end
         S_PRGA_GO, S_PRGA_ACK, S_PRGA_WAIT: begin
            o_s_addr   = i_prga_s_addr;
            o_s_wrdata = i_prga_s_wrdata;
            o_s_wren   = i_prga_s_wren;
         end
         default: begin
            o_s_addr   = 8'd0;
            o_s_wrdata = 8'd0;
            o_s_wren   = 1'b0;
         end
      endcase
   end

endmodule
